// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared debounce types, width helpers and parameter checks
// Contents: scan_state_t (IDLE/WAIT/SAMPLE), width_of() for min-1-bit clog2 widths,
//           params_legal() for the parameter ranges the debounce blocks support.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2
    } scan_state_t;

    // clog2 that never returns zero, so a single-value field still gets one bit
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_legal(input int num_sw, input int tick_div,
                                        input int stable_scans);
        return (num_sw >= 1) && (tick_div >= 2) && (stable_scans >= 2);
    endfunction

endpackage

// File: rtl/debounce_scan_scheduler_if.sv
// rtl/debounce_scan_scheduler_if.sv - switch-in / debounced-out bundle of the scan scheduler
// Signals: i_enable, i_switch[NUM_SW] toward the scheduler; o_debounced, o_press, o_release
//          [NUM_SW], o_scan_idx[IDX_W], o_busy back from it.
// Modports: master = user side driving switches/enable, slave = the scheduler.
interface debounce_scan_scheduler_if #(
    parameter int NUM_SW = 4,
    parameter int IDX_W  = 2
);
    logic              i_enable;
    logic [NUM_SW-1:0] i_switch;
    logic [NUM_SW-1:0] o_debounced;
    logic [NUM_SW-1:0] o_press;
    logic [NUM_SW-1:0] o_release;
    logic [IDX_W-1:0]  o_scan_idx;
    logic              o_busy;

    modport master (
        output i_enable, i_switch,
        input  o_debounced, o_press, o_release, o_scan_idx, o_busy
    );

    modport slave (
        input  i_enable, i_switch,
        output o_debounced, o_press, o_release, o_scan_idx, o_busy
    );
endinterface

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - scan-slot prescaler with terminal-count flag
// Ports: clk, rst_n (async active-low), clear (sync zero, wins over enable),
//        enable (count up), tc (count == TICK_DIV-2 while enabled).
module scan_tick_gen
    import debounce_pkg::*;
#(
    parameter int TICK_DIV = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int           W    = width_of(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 2);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Terminal count is the last WAIT clock; the following SAMPLE clock completes the slot.
    assign tc = enable && (count == LAST);

endmodule

// File: rtl/debounce_scan_scheduler.sv
// rtl/debounce_scan_scheduler.sv - round-robin time-multiplexed switch debouncer
// Ports: i_clk, i_rst_n (async active-low); bus (slave): i_enable, i_switch in;
//        o_debounced, o_press, o_release, o_scan_idx, o_busy out (all registered).
module debounce_scan_scheduler
    import debounce_pkg::*;
#(
    parameter int NUM_SW       = 4,
    parameter int TICK_DIV     = 250,
    parameter int STABLE_SCANS = 100
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    debounce_scan_scheduler_if.slave    bus
);
    localparam int                   IDX_W   = width_of(NUM_SW);
    localparam int                   CNT_W   = width_of(STABLE_SCANS);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(STABLE_SCANS - 1);
    localparam logic [IDX_W-1:0]     IDX_MAX = IDX_W'(NUM_SW - 1);

    if (!params_legal(NUM_SW, TICK_DIV, STABLE_SCANS)) begin : g_bad_params
        $fatal(1, "debounce_scan_scheduler: illegal parameter combination");
    end

    logic [NUM_SW-1:0] sync1;
    logic [NUM_SW-1:0] sync2;
    scan_state_t       state;
    logic [IDX_W-1:0]  idx;
    logic              busy;
    logic [NUM_SW-1:0] deb;
    logic [NUM_SW-1:0] press;
    logic [NUM_SW-1:0] rel;
    logic [CNT_W-1:0]  cnt [NUM_SW];
    logic              tick_tc;
    logic              tick_clear;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.i_switch;
            sync2 <= sync1;
        end
    end

    // Prescaler only runs in WAIT; it is zeroed on leaving WAIT for any reason.
    assign tick_clear = (state != ST_WAIT) || !bus.i_enable || tick_tc;

    scan_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clear  (tick_clear),
        .enable (state == ST_WAIT),
        .tc     (tick_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            idx   <= '0;
            deb   <= '0;
            press <= '0;
            rel   <= '0;
            for (int k = 0; k < NUM_SW; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            press <= '0;
            rel   <= '0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_enable) begin
                        state <= ST_WAIT;
                        busy  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!bus.i_enable) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (tick_tc) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    // Only the serviced channel can commit, so pulses are never simultaneous.
                    if (sync2[idx] == deb[idx]) begin
                        cnt[idx] <= '0;
                    end else if (cnt[idx] == CNT_MAX) begin
                        cnt[idx] <= '0;
                        deb[idx] <= sync2[idx];
                        if (sync2[idx]) begin
                            press[idx] <= 1'b1;
                        end else begin
                            rel[idx] <= 1'b1;
                        end
                    end else begin
                        cnt[idx] <= cnt[idx] + 1'b1;
                    end
                    idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
                    if (bus.i_enable) begin
                        state <= ST_WAIT;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_debounced = deb;
    assign bus.o_press     = press;
    assign bus.o_release   = rel;
    assign bus.o_scan_idx  = idx;
    assign bus.o_busy      = busy;

endmodule

// File: tb/tb_debounce_scan_scheduler.sv
// tb/tb_debounce_scan_scheduler.sv - scoreboard bench for debounce_scan_scheduler
module tb_debounce_scan_scheduler;

    localparam int NUM_SW       = 4;
    localparam int TICK_DIV     = 4;
    localparam int STABLE_SCANS = 3;

    typedef struct {
        int ch;
        bit is_press;
        int t0;
        int lo;
        int hi;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   pulse_cyc [NUM_SW];
    exp_t sb [$];

    debounce_scan_scheduler_if #(.NUM_SW(NUM_SW), .IDX_W(2)) bus ();

    debounce_scan_scheduler #(
        .NUM_SW       (NUM_SW),
        .TICK_DIV     (TICK_DIV),
        .STABLE_SCANS (STABLE_SCANS)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int ch, input bit is_press, input int lo, input int hi);
        exp_t e;
        e.ch = ch; e.is_press = is_press; e.t0 = cyc; e.lo = lo; e.hi = hi;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, sb.size(), 0);
    endtask

    // Park on the negedge right after the scanner wraps to channel 0 (channel 3 just sampled).
    task automatic align_idx0();
        int k = 0;
        while (bus.o_scan_idx == 2'd0 && k < 20) begin tick(1); k++; end
        while (bus.o_scan_idx != 2'd0 && k < 40) begin tick(1); k++; end
        check("align_idx0", bus.o_scan_idx, 0);
    endtask

    // Pulse monitor: every pulse must be one-hot and match the head of the scoreboard.
    always @(negedge clk) begin
        logic [NUM_SW-1:0] ev;
        int                ch;
        int                lat;
        exp_t              e;
        ev = bus.o_press | bus.o_release;
        if (ev != '0) begin
            check("pulse_onehot", $countones(ev), 1);
            ch = 0;
            for (int i = NUM_SW - 1; i >= 0; i--) if (ev[i]) ch = i;
            pulse_cyc[ch] = cyc;
            check("pulse_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                lat = cyc - e.t0;
                check("pulse_channel", ch, e.ch);
                check("pulse_kind_press", bus.o_press[ch], e.is_press);
                check("pulse_latency_ok", (lat >= e.lo && lat <= e.hi), 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int saved_idx;
        int k;
        bus.i_enable = 1'b1;
        bus.i_switch = 4'b0000;

        // Reset values
        tick(3);
        check("rst_debounced", bus.o_debounced, 0);
        check("rst_press", bus.o_press, 0);
        check("rst_release", bus.o_release, 0);
        check("rst_scan_idx", bus.o_scan_idx, 0);
        check("rst_busy", bus.o_busy, 0);
        rst_n = 1'b1;
        tick(2);
        check("busy_after_enable", bus.o_busy, 1);

        // Round-robin scan index, 4 clocks per slot
        k = 0;
        while (bus.o_scan_idx == 2'd0 && k < 20) begin tick(1); k++; end
        check("scan_idx_first", bus.o_scan_idx, 1);
        for (int s = 0; s < 4; s++) begin
            tick(4);
            check("scan_idx_step", bus.o_scan_idx, (s + 2) % 4);
        end

        // Clean step on channel 2
        bus.i_switch[2] = 1'b1;
        push(2, 1'b1, 35, 50);
        drain("drain_ch2_press", 100);
        check("deb_ch2_high", bus.o_debounced, 4'b0100);

        // 20-clock glitch on channel 1 must be rejected
        bus.i_switch[1] = 1'b1;
        tick(20);
        bus.i_switch[1] = 1'b0;
        tick(60);
        check("deb_after_glitch", bus.o_debounced, 4'b0100);

        // Simultaneous steps on channels 0 and 3
        align_idx0();
        bus.i_switch[0] = 1'b1;
        bus.i_switch[3] = 1'b1;
        push(0, 1'b1, 35, 50);
        push(3, 1'b1, 35, 50);
        drain("drain_ch0_ch3", 100);
        check("ch3_minus_ch0_gap", pulse_cyc[3] - pulse_cyc[0], 12);
        check("deb_ch0_ch3", bus.o_debounced, 4'b1101);

        // Enable dropped mid-debounce on channel 1
        bus.i_switch[1] = 1'b1;
        push(1, 1'b1, 35, 2000);
        tick(20);
        bus.i_enable = 1'b0;
        tick(2);
        check("paused_busy", bus.o_busy, 0);
        saved_idx = bus.o_scan_idx;
        tick(48);
        check("paused_busy_late", bus.o_busy, 0);
        check("paused_idx_held", bus.o_scan_idx, saved_idx);
        check("paused_deb_held", bus.o_debounced, 4'b1101);
        bus.i_enable = 1'b1;
        drain("drain_ch1_resume", 200);
        check("deb_ch1_resume", bus.o_debounced, 4'b1111);

        // Release on channel 2
        bus.i_switch[2] = 1'b0;
        push(2, 1'b0, 35, 50);
        drain("drain_ch2_release", 100);
        check("deb_ch2_low", bus.o_debounced, 4'b1011);

        // Reset one clock before the channel 0 release would commit (edge +36)
        align_idx0();
        bus.i_switch[0] = 1'b0;
        tick(35);
        rst_n = 1'b0;
        #1;
        check("midrst_debounced", bus.o_debounced, 0);
        check("midrst_press", bus.o_press, 0);
        check("midrst_release", bus.o_release, 0);
        check("midrst_scan_idx", bus.o_scan_idx, 0);
        check("midrst_busy", bus.o_busy, 0);
        tick(2);
        rst_n = 1'b1;
        // Switches 1 and 3 still high: re-accepted from zero counts with press pulses
        push(1, 1'b1, 35, 50);
        push(3, 1'b1, 35, 50);
        drain("drain_after_reset", 100);
        check("deb_after_reset", bus.o_debounced, 4'b1010);

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
